// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS multi-cycle control path.
// Opcode/funct/rt tables, FSM states, PC source and instruction class.
package mips_cpu_pkg;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01,
    OP_J       = 6'h02, OP_JAL    = 6'h03,
    OP_BEQ     = 6'h04, OP_BNE    = 6'h05,
    OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07,
    OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09,
    OP_SLTI    = 6'h0A, OP_SLTIU  = 6'h0B,
    OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D,
    OP_XORI    = 6'h0E, OP_LUI    = 6'h0F,
    OP_LB      = 6'h20, OP_LH     = 6'h21,
    OP_LWL     = 6'h22, OP_LW     = 6'h23,
    OP_LBU     = 6'h24, OP_LHU    = 6'h25,
    OP_LWR     = 6'h26, OP_SB     = 6'h28,
    OP_SH      = 6'h29, OP_SW     = 6'h2B
  } op_t;

  typedef enum logic [5:0] {
    F_SLL   = 6'h00, F_SRL   = 6'h02,
    F_SRA   = 6'h03, F_SLLV  = 6'h04,
    F_SRLV  = 6'h06, F_SRAV  = 6'h07,
    F_JR    = 6'h08, F_JALR  = 6'h09,
    F_MFHI  = 6'h10, F_MTHI  = 6'h11,
    F_MFLO  = 6'h12, F_MTLO  = 6'h13,
    F_MULT  = 6'h18, F_MULTU = 6'h19,
    F_DIV   = 6'h1A, F_DIVU  = 6'h1B,
    F_ADD   = 6'h20, F_ADDU  = 6'h21,
    F_SUB   = 6'h22, F_SUBU  = 6'h23,
    F_AND   = 6'h24, F_OR    = 6'h25,
    F_XOR   = 6'h26, F_NOR   = 6'h27,
    F_SLT   = 6'h2A, F_SLTU  = 6'h2B
  } funct_t;

  typedef enum logic [4:0] {
    RT_BLTZ   = 5'h00, RT_BGEZ   = 5'h01,
    RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11
  } rt_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0, S_EXEC = 3'd1,
    S_MEM    = 3'd2, S_WB   = 3'd3,
    S_MULDIV = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0, PC_BRANCH = 2'd1,
    PC_JIMM   = 2'd2, PC_REG    = 2'd3
  } pc_src_t;

  typedef enum logic [3:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE,
    CLS_BRANCH, CLS_JUMP, CLS_JUMPREG,
    CLS_MULDIV, CLS_HILO_MT, CLS_HILO_MF,
    CLS_ILLEGAL
  } cls_t;

  function automatic logic is_redirect(cls_t c);
    return c inside {CLS_BRANCH, CLS_JUMP, CLS_JUMPREG};
  endfunction

endpackage

// File: rtl/mips_cpu_control_fsm_if.sv
// Controller <-> datapath/memory signal bundle.
// master = control FSM, slave = datapath and memory side.
interface mips_cpu_control_fsm_if;
  import mips_cpu_pkg::*;

  logic [31:0] instr;
  logic        alu_cond;
  logic        jump_target_zero;
  logic        mem_waitrequest;
  logic        active;
  state_t      state;
  logic        mem_read;
  logic        mem_write;
  logic        mem_addr_sel;
  logic        ir_en;
  logic        pc_en;
  pc_src_t     pc_src;
  logic        target_capture;
  logic        reg_write;
  logic        hilo_write;
  logic        muldiv_start;
  logic        stall;
  logic        illegal;

  modport master (
    input  instr, alu_cond, jump_target_zero,
    input  mem_waitrequest,
    output active, state, mem_read, mem_write,
    output mem_addr_sel, ir_en, pc_en, pc_src,
    output target_capture, reg_write, hilo_write,
    output muldiv_start, stall, illegal
  );

  modport slave (
    output instr, alu_cond, jump_target_zero,
    output mem_waitrequest,
    input  active, state, mem_read, mem_write,
    input  mem_addr_sel, ir_en, pc_en, pc_src,
    input  target_capture, reg_write, hilo_write,
    input  muldiv_start, stall, illegal
  );

endinterface

// File: rtl/mips_cpu_instr_class.sv
// Combinational instruction classifier.
// Maps the IR word to a control class, a link flag and a divide flag.
module mips_cpu_instr_class
  import mips_cpu_pkg::*;
(
  input  logic [31:0] instr_i,
  output cls_t        cls_o,
  output logic        link_o,
  output logic        is_div_o
);

  op_t    op;
  funct_t fn;
  rt_t    rt;
  logic   unused_fields;

  assign op = op_t'(instr_i[31:26]);
  assign fn = funct_t'(instr_i[5:0]);
  assign rt = rt_t'(instr_i[20:16]);
  assign unused_fields = ^{instr_i[25:21], instr_i[15:6]};

  // Decode opcode, then funct or rt where the opcode defers to them.
  always_comb begin
    cls_o    = CLS_ILLEGAL;
    link_o   = 1'b0;
    is_div_o = 1'b0;
    unique case (op)
      OP_SPECIAL: begin
        unique case (fn)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
          F_XOR, F_NOR, F_SLT, F_SLTU:
            cls_o = CLS_ALU;
          F_JR:
            cls_o = CLS_JUMPREG;
          F_JALR: begin
            cls_o  = CLS_JUMPREG;
            link_o = 1'b1;
          end
          F_MFHI, F_MFLO:
            cls_o = CLS_HILO_MF;
          F_MTHI, F_MTLO:
            cls_o = CLS_HILO_MT;
          F_MULT, F_MULTU:
            cls_o = CLS_MULDIV;
          F_DIV, F_DIVU: begin
            cls_o    = CLS_MULDIV;
            is_div_o = 1'b1;
          end
          default:
            cls_o = CLS_ILLEGAL;
        endcase
      end
      OP_REGIMM: begin
        unique case (rt)
          RT_BLTZ, RT_BGEZ:
            cls_o = CLS_BRANCH;
          RT_BLTZAL, RT_BGEZAL: begin
            cls_o  = CLS_BRANCH;
            link_o = 1'b1;
          end
          default:
            cls_o = CLS_ILLEGAL;
        endcase
      end
      OP_J:
        cls_o = CLS_JUMP;
      OP_JAL: begin
        cls_o  = CLS_JUMP;
        link_o = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
        cls_o = CLS_BRANCH;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        cls_o = CLS_ALU;
      OP_LB, OP_LH, OP_LWL, OP_LW,
      OP_LBU, OP_LHU, OP_LWR:
        cls_o = CLS_LOAD;
      OP_SB, OP_SH, OP_SW:
        cls_o = CLS_STORE;
      default:
        cls_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_cpu_control_fsm.sv
// Multi-cycle control sequencer: fetch/exec/mem/wb/muldiv/halt.
// Tracks a pending redirect so it lands after the delay slot.
module mips_cpu_control_fsm
  import mips_cpu_pkg::*;
#(
  parameter int MUL_CYCLES     = 4,
  parameter int DIV_CYCLES     = 33,
  parameter bit HAS_DELAY_SLOT = 1'b1,
  parameter int CNT_W          = $clog2(DIV_CYCLES + 1)
) (
  input logic                    clk,
  input logic                    reset,
  mips_cpu_control_fsm_if.master bus
);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  pc_src_t          kind_q, kind_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  cls_t    cls;
  logic    link;
  logic    is_div;
  logic    in_slot;
  logic    done;
  logic    redir;
  pc_src_t rkind;
  logic    rhalt;

  logic    mem_read, mem_write, mem_addr_sel;
  logic    ir_en, pc_en, target_capture;
  logic    reg_write, hilo_write;
  logic    muldiv_start, stall, illegal;
  pc_src_t pc_src;

  mips_cpu_instr_class u_class (
    .instr_i  (bus.instr),
    .cls_o    (cls),
    .link_o   (link),
    .is_div_o (is_div)
  );

  // Only meaningful when redirects wait one instruction.
  assign in_slot = HAS_DELAY_SLOT && pend_q;

  // State, pending redirect and stall counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pend_q  <= 1'b0;
      kind_q  <= PC_SEQ;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      kind_q  <= kind_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and per-state strobes; strobes held low in reset.
  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    kind_d         = kind_q;
    halt_d         = halt_q;
    cnt_d          = cnt_q;
    done           = 1'b0;
    redir          = 1'b0;
    rkind          = PC_SEQ;
    rhalt          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr_sel   = 1'b0;
    ir_en          = 1'b0;
    pc_en          = 1'b0;
    pc_src         = PC_SEQ;
    target_capture = 1'b0;
    reg_write      = 1'b0;
    hilo_write     = 1'b0;
    muldiv_start   = 1'b0;
    stall          = 1'b0;
    illegal        = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (!bus.mem_waitrequest) begin
            ir_en   = 1'b1;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (cls)
            CLS_ALU, CLS_HILO_MF: begin
              reg_write = 1'b1;
              done      = 1'b1;
            end
            CLS_LOAD, CLS_STORE:
              state_d = S_MEM;
            CLS_HILO_MT: begin
              hilo_write = 1'b1;
              done       = 1'b1;
            end
            CLS_MULDIV: begin
              muldiv_start = 1'b1;
              cnt_d        = is_div ? DIV_LD : MUL_LD;
              state_d      = S_MULDIV;
            end
            CLS_BRANCH: begin
              reg_write = link;
              redir     = bus.alu_cond;
              rkind     = PC_BRANCH;
              done      = 1'b1;
            end
            CLS_JUMP: begin
              reg_write = link;
              redir     = 1'b1;
              rkind     = PC_JIMM;
              done      = 1'b1;
            end
            CLS_JUMPREG: begin
              reg_write = link;
              redir     = 1'b1;
              rkind     = PC_REG;
              rhalt     = bus.jump_target_zero;
              done      = 1'b1;
            end
            default: begin
              illegal = 1'b1;
              done    = 1'b1;
            end
          endcase
          // A redirect in a delay slot is dropped; the first one wins.
          if (in_slot && is_redirect(cls)) begin
            illegal = 1'b1;
            redir   = 1'b0;
            rhalt   = 1'b0;
          end
          target_capture = redir;
        end
        S_MEM: begin
          mem_addr_sel = 1'b1;
          mem_read     = (cls == CLS_LOAD);
          mem_write    = (cls == CLS_STORE);
          if (!bus.mem_waitrequest) begin
            if (cls == CLS_LOAD) state_d = S_WB;
            else done = 1'b1;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          done      = 1'b1;
        end
        S_MULDIV: begin
          stall = 1'b1;
          if (cnt_q == '0) begin
            hilo_write = 1'b1;
            done       = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase

      if (done) begin
        pc_en   = 1'b1;
        state_d = S_FETCH;
        if (HAS_DELAY_SLOT) begin
          if (pend_q) begin
            pc_src = kind_q;
            pend_d = 1'b0;
            halt_d = 1'b0;
            if (halt_q) state_d = S_HALT;
          end
          if (redir) begin
            pend_d = 1'b1;
            kind_d = rkind;
            halt_d = rhalt;
          end
        end else if (redir) begin
          pc_src = rkind;
          if (rhalt) state_d = S_HALT;
        end
      end
    end
  end

  assign bus.active         = (state_q != S_HALT);
  assign bus.state          = state_q;
  assign bus.mem_read       = mem_read;
  assign bus.mem_write      = mem_write;
  assign bus.mem_addr_sel   = mem_addr_sel;
  assign bus.ir_en          = ir_en;
  assign bus.pc_en          = pc_en;
  assign bus.pc_src         = pc_src;
  assign bus.target_capture = target_capture;
  assign bus.reg_write      = reg_write;
  assign bus.hilo_write     = hilo_write;
  assign bus.muldiv_start   = muldiv_start;
  assign bus.stall          = stall;
  assign bus.illegal        = illegal;

endmodule
